// File: rtl/mshr_timer_release_seq.sv
// Holds L2 MSHR w_timer lanes at zero until DDR calibration completes,
// then releases them one at a time after a hold window and stagger.
module mshr_timer_release_seq #(
    parameter int N_MSHR         = 5,
    parameter int HOLD_CYCLES    = 10000,
    parameter int STAGGER_CYCLES = 4,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              init_calib_complete,
    output logic [N_MSHR-1:0] timer_hold,
    output logic              sys_ready,
    output logic              calib_timeout,
    output logic [2:0]        state_o
);

    localparam int IW = $clog2(N_MSHR) + 1;

    typedef enum logic [2:0] {
        WAIT_CALIB = 3'd0,
        HOLD       = 3'd1,
        RELEASE    = 3'd2,
        READY      = 3'd3,
        FAIL       = 3'd4
    } state_t;

    state_t            state, state_n;
    logic              sync_q, calib_s;
    logic [31:0]       cnt, cnt_n, cnt_inc;
    logic [IW-1:0]     idx, idx_n;
    logic [N_MSHR-1:0] timer_hold_n;
    logic              sys_ready_n, calib_timeout_n;

    assign state_o = state;
    // Saturate so a disabled timeout cannot let the counter wrap.
    assign cnt_inc = (cnt == '1) ? cnt : cnt + 32'd1;

    always_comb begin
        state_n         = state;
        cnt_n           = cnt;
        idx_n           = idx;
        timer_hold_n    = timer_hold;
        sys_ready_n     = sys_ready;
        calib_timeout_n = calib_timeout;
        case (state)
            WAIT_CALIB: begin
                cnt_n        = cnt_inc;
                timer_hold_n = '1;
                sys_ready_n  = 1'b0;
                if (calib_s) begin
                    state_n = HOLD;
                    cnt_n   = '0;
                end else if (TIMEOUT_CYCLES != 0 &&
                             cnt == 32'(TIMEOUT_CYCLES - 1)) begin
                    state_n         = FAIL;
                    calib_timeout_n = 1'b1;
                    cnt_n           = '0;
                end
            end
            HOLD, RELEASE, READY: begin
                // A calibration drop wins over any release due this edge.
                if (!calib_s) begin
                    state_n      = WAIT_CALIB;
                    timer_hold_n = '1;
                    sys_ready_n  = 1'b0;
                    cnt_n        = '0;
                    idx_n        = '0;
                end else if (state == HOLD) begin
                    cnt_n = cnt_inc;
                    if (cnt == 32'(HOLD_CYCLES - 1)) begin
                        timer_hold_n[0] = 1'b0;
                        idx_n           = IW'(1);
                        cnt_n           = '0;
                        if (N_MSHR == 1) begin
                            state_n     = READY;
                            sys_ready_n = 1'b1;
                        end else begin
                            state_n = RELEASE;
                        end
                    end
                end else if (state == RELEASE) begin
                    cnt_n = cnt_inc;
                    if (cnt == 32'(STAGGER_CYCLES - 1)) begin
                        for (int i = 0; i < N_MSHR; i++)
                            if (idx == IW'(i))
                                timer_hold_n[i] = 1'b0;
                        idx_n = idx + IW'(1);
                        cnt_n = '0;
                        if (idx == IW'(N_MSHR - 1)) begin
                            state_n     = READY;
                            sys_ready_n = 1'b1;
                        end
                    end
                end else begin
                    cnt_n = '0;
                end
            end
            FAIL: begin
                timer_hold_n    = '1;
                sys_ready_n     = 1'b0;
                calib_timeout_n = 1'b1;
                cnt_n           = '0;
            end
            default: begin
                state_n         = WAIT_CALIB;
                timer_hold_n    = '1;
                sys_ready_n     = 1'b0;
                calib_timeout_n = 1'b0;
                cnt_n           = '0;
                idx_n           = '0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q        <= 1'b0;
            calib_s       <= 1'b0;
            state         <= WAIT_CALIB;
            cnt           <= '0;
            idx           <= '0;
            timer_hold    <= '1;
            sys_ready     <= 1'b0;
            calib_timeout <= 1'b0;
        end else begin
            sync_q        <= init_calib_complete;
            calib_s       <= sync_q;
            state         <= state_n;
            cnt           <= cnt_n;
            idx           <= idx_n;
            timer_hold    <= timer_hold_n;
            sys_ready     <= sys_ready_n;
            calib_timeout <= calib_timeout_n;
        end
    end

endmodule
